// File: rtl/uart_core.sv
// uart_core: full-duplex UART engine with a shared baud tick, configurable
// frame format, TX/RX FIFOs behind valid/ready handshakes and sticky error flags.
module uart_core #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_reset,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_two_stop,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_TX,
  output logic                 o_tx_busy,
  input  logic                 i_RX,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  input  logic                 i_err_clear
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // ---------------------------------------------------------------------
  // Oversample tick generator
  // ---------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] tick_cnt;
  logic                 tick;

  // A ">=" compare lets the counter recover at once if the divisor shrinks
  assign tick = (tick_cnt >= i_divisor);

  // Count 0..divisor and wrap, producing one tick per divisor+1 clocks
  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + DIV_WIDTH'(1);
  end

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wr_ptr, tx_rd_ptr;
  logic [AW:0]          tx_count;
  logic                 tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign o_tx_ready = (tx_count != FULL_COUNT);
  assign tx_push    = i_tx_valid & o_tx_ready;
  assign tx_head    = tx_mem[tx_rd_ptr];

  // Storage array needs no reset; occupancy alone defines validity
  always_ff @(posedge i_Clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= i_tx_data;
  end

  // Pointer and occupancy bookkeeping for the TX queue
  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (AW+1)'(1);
        2'b01:   tx_count <= tx_count - (AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // TX framing FSM
  // ---------------------------------------------------------------------
  tx_state_t            tx_state;
  logic [4:0]           tx_sub;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par_en, tx_par_bit, tx_two_stop, tx_line;
  logic [4:0]           tx_stop_last;
  logic                 tx_frame_end;

  assign tx_stop_last = tx_two_stop ? 5'd31 : 5'd15;
  assign tx_frame_end = tick && (tx_state == TX_STOP) && (tx_sub == tx_stop_last);
  assign tx_pop       = tick && (tx_count != '0) &&
                        ((tx_state == TX_IDLE) || tx_frame_end);

  assign o_TX      = tx_line;
  assign o_tx_busy = (tx_state != TX_IDLE);

  // Serialise frames; a pop latches the whole frame format so mid-frame
  // configuration changes only affect the next frame
  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      tx_state    <= TX_IDLE;
      tx_sub      <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      tx_par_en   <= 1'b0;
      tx_par_bit  <= 1'b0;
      tx_two_stop <= 1'b0;
      tx_line     <= 1'b1;
    end else if (tx_pop) begin
      tx_shift    <= tx_head;
      tx_par_en   <= ^i_parity_mode;
      tx_par_bit  <= (^tx_head) ^ i_parity_mode[1];
      tx_two_stop <= i_two_stop;
      tx_state    <= TX_START;
      tx_sub      <= '0;
      tx_line     <= 1'b0;
    end else if (tick) begin
      case (tx_state)
        TX_START: begin
          if (tx_sub == 5'd15) begin
            tx_state <= TX_DATA;
            tx_sub   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
          end else begin
            tx_sub <= tx_sub + 5'd1;
          end
        end
        TX_DATA: begin
          if (tx_sub == 5'd15) begin
            tx_sub <= '0;
            if (tx_bit == LAST_BIT) begin
              if (tx_par_en) begin
                tx_state <= TX_PARITY;
                tx_line  <= tx_par_bit;
              end else begin
                tx_state <= TX_STOP;
                tx_line  <= 1'b1;
              end
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= tx_shift >> 1;
              tx_line  <= tx_shift[1];
            end
          end else begin
            tx_sub <= tx_sub + 5'd1;
          end
        end
        TX_PARITY: begin
          if (tx_sub == 5'd15) begin
            tx_state <= TX_STOP;
            tx_sub   <= '0;
            tx_line  <= 1'b1;
          end else begin
            tx_sub <= tx_sub + 5'd1;
          end
        end
        TX_STOP: begin
          if (tx_sub == tx_stop_last) begin
            tx_state <= TX_IDLE;
            tx_sub   <= '0;
            tx_line  <= 1'b1;
          end else begin
            tx_sub <= tx_sub + 5'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX synchroniser and framing FSM
  // ---------------------------------------------------------------------
  logic                 rx_meta, rx_sync;
  rx_state_t            rx_state;
  logic [3:0]           rx_sub;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_en, rx_odd;
  logic                 rx_push, parity_set, frame_set;

  // Two-flop synchroniser, idling at the line's mark level
  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_RX;
      rx_sync <= rx_meta;
    end
  end

  assign rx_push    = tick && (rx_state == RX_STOP) && (rx_sub == 4'd15);
  assign frame_set  = rx_push && !rx_sync;
  assign parity_set = tick && (rx_state == RX_PARITY) && (rx_sub == 4'd15) &&
                      (rx_sync != ((^rx_shift) ^ rx_odd));

  // Find a start edge, confirm it mid-bit, then sample every 16 ticks
  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      rx_state  <= RX_IDLE;
      rx_sub    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_par_en <= 1'b0;
      rx_odd    <= 1'b0;
    end else if (tick) begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state  <= RX_START;
            rx_sub    <= '0;
            rx_par_en <= ^i_parity_mode;
            rx_odd    <= i_parity_mode[1];
          end
        end
        RX_START: begin
          if (rx_sub == 4'd7) begin
            rx_sub <= '0;
            rx_bit <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_sub <= rx_sub + 4'd1;
          end
        end
        RX_DATA: begin
          if (rx_sub == 4'd15) begin
            rx_sub   <= '0;
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
            else                    rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_sub <= rx_sub + 4'd1;
          end
        end
        RX_PARITY: begin
          if (rx_sub == 4'd15) begin
            rx_sub   <= '0;
            rx_state <= RX_STOP;
          end else begin
            rx_sub <= rx_sub + 4'd1;
          end
        end
        RX_STOP: begin
          if (rx_sub == 4'd15) begin
            rx_sub   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_sub <= rx_sub + 4'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO (first-word fall-through)
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]          rx_count;
  logic                 rx_pop, rx_full, rx_accept, overrun_set;

  assign o_rx_valid  = (rx_count != '0);
  assign o_rx_data   = o_rx_valid ? rx_mem[rx_rd_ptr] : '0;
  assign rx_pop      = o_rx_valid & i_rx_ready;
  assign rx_full     = (rx_count == FULL_COUNT);
  assign rx_accept   = rx_push && (!rx_full || rx_pop);
  assign overrun_set = rx_push && rx_full && !rx_pop;

  // A full FIFO popped in the same cycle frees the slot being written
  always_ff @(posedge i_Clock) begin
    if (rx_accept) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  // Pointer and occupancy bookkeeping for the RX queue
  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_accept) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_accept, rx_pop})
        2'b10:   rx_count <= rx_count + (AW+1)'(1);
        2'b01:   rx_count <= rx_count - (AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (parity_set)       o_parity_err <= 1'b1;
      else if (i_err_clear) o_parity_err <= 1'b0;
      if (frame_set)        o_frame_err  <= 1'b1;
      else if (i_err_clear) o_frame_err  <= 1'b0;
      if (overrun_set)      o_overrun    <= 1'b1;
      else if (i_err_clear) o_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: table-driven and randomised checks of uart_core against a
// bit-list frame model, plus hand-written RX error, overrun and reset sequences.
module tb_uart_core;

  localparam int DB = 8;
  localparam int DEPTH = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] divisor;
  logic [1:0]    parity_mode;
  logic          two_stop;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_line;
  logic          tx_busy;
  logic          rx_line;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          parity_err, frame_err, overrun;
  logic          err_clear;
  logic          loopback;
  logic          drv_rx;

  int vectors = 0;
  int miscompares = 0;

  logic cap_wave[$];
  logic model_bits[$];

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       two;
    int         div;
    logic       has_par;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  assign rx_line = loopback ? tx_line : drv_rx;

  uart_core #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
    .i_Clock      (clk),
    .i_reset      (rst),
    .i_divisor    (divisor),
    .i_parity_mode(parity_mode),
    .i_two_stop   (two_stop),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .o_TX         (tx_line),
    .o_tx_busy    (tx_busy),
    .i_RX         (rx_line),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .i_rx_ready   (rx_ready),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err),
    .o_overrun    (overrun),
    .i_err_clear  (err_clear)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkFlags(input string name, input logic p, input logic f, input logic o);
    @(negedge clk);
    checkOutput({name, "_parity_err"}, 32'(parity_err), 32'(p));
    checkOutput({name, "_frame_err"},  32'(frame_err),  32'(f));
    checkOutput({name, "_overrun"},    32'(overrun),    32'(o));
  endtask

  // Frame as a list of line levels, one entry per bit period
  function automatic void buildFrame(input logic [7:0] data, input logic [1:0] mode,
                                     input logic two);
    model_bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) model_bits.push_back(data[i]);
    if (mode == 2'b01) model_bits.push_back(^data);
    if (mode == 2'b10) model_bits.push_back(~(^data));
    model_bits.push_back(1'b1);
    if (two) model_bits.push_back(1'b1);
  endfunction

  task automatic pushTx(input logic [7:0] data);
    int guard;
    @(posedge clk); #1;
    tx_data  = data;
    tx_valid = 1'b1;
    guard    = 0;
    @(negedge clk);
    while (!tx_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!tx_ready) checkOutput("push_timeout", 32'(tx_ready), 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] mode,
                               input logic two, input int div);
    divisor     = DW'(div);
    parity_mode = mode;
    two_stop    = two;
    pushTx(data);
  endtask

  task automatic captureTx();
    int guard;
    cap_wave.delete();
    guard = 0;
    @(negedge clk);
    while (!tx_busy && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (!tx_busy) begin
      checkOutput("busy_timeout", 32'(tx_busy), 32'd1);
      return;
    end
    guard = 0;
    while (tx_busy && guard < 8000) begin
      cap_wave.push_back(tx_line);
      @(negedge clk);
      guard++;
    end
    if (tx_busy) checkOutput("busy_stuck", 32'(tx_busy), 32'd0);
  endtask

  task automatic checkWave(input string name, input int bitclk);
    int   idx;
    logic v;
    for (int k = 0; k < model_bits.size(); k++) begin
      idx = k * bitclk + bitclk / 2;
      v   = (idx < cap_wave.size()) ? cap_wave[idx] : 1'bx;
      checkOutput($sformatf("%s_bit%0d", name, k), 32'(v), 32'(model_bits[k]));
    end
  endtask

  task automatic popRx(input string name, input logic [7:0] exp);
    @(negedge clk);
    checkOutput({name, "_valid"}, 32'(rx_valid), 32'd1);
    checkOutput({name, "_data"},  32'(rx_data),  32'(exp));
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  // Drive one RX frame directly at divisor 0 (16 clocks per bit)
  task automatic driveRxFrame(input logic [7:0] data, input logic has_par,
                              input logic par, input logic stop_val);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(data[i]);
    if (has_par) bits.push_back(par);
    bits.push_back(stop_val);
    @(posedge clk); #1;
    foreach (bits[i]) begin
      drv_rx = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    drv_rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic clearErrors();
    @(posedge clk); #1;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         bc;
    int         guard;
    logic [7:0] rd;
    logic [1:0] rmode;
    logic       rtwo;
    int         rdiv;

    vecs[0] = '{8'hA5, 2'b00, 1'b0, 0, 1'b0, 1'b0, 160};
    vecs[1] = '{8'h01, 2'b10, 1'b0, 1, 1'b1, 1'b0, 352};
    vecs[2] = '{8'h07, 2'b01, 1'b0, 0, 1'b1, 1'b1, 176};
    vecs[3] = '{8'h00, 2'b10, 1'b1, 0, 1'b1, 1'b1, 192};
    vecs[4] = '{8'h3C, 2'b01, 1'b1, 3, 1'b1, 1'b0, 768};
    vecs[5] = '{8'h80, 2'b11, 1'b1, 2, 1'b0, 1'b0, 528};

    rst         = 1'b0;
    divisor     = '0;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    tx_data     = '0;
    tx_valid    = 1'b0;
    rx_ready    = 1'b0;
    err_clear   = 1'b0;
    loopback    = 1'b1;
    drv_rx      = 1'b1;
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_tx",       32'(tx_line),    32'd1);
    checkOutput("rst_busy",     32'(tx_busy),    32'd0);
    checkOutput("rst_ready",    32'(tx_ready),   32'd1);
    checkOutput("rst_rx_valid", 32'(rx_valid),   32'd0);
    checkOutput("rst_rx_data",  32'(rx_data),    32'd0);
    checkOutput("rst_perr",     32'(parity_err), 32'd0);
    checkOutput("rst_ferr",     32'(frame_err),  32'd0);
    checkOutput("rst_ovr",      32'(overrun),    32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] table-driven loopback frames");
    for (int v = 0; v < 6; v++) begin
      loopback = 1'b1;
      bc = 16 * (vecs[v].div + 1);
      applyStimulus(vecs[v].data, vecs[v].mode, vecs[v].two, vecs[v].div);
      captureTx();
      checkOutput($sformatf("vec%0d_len", v), 32'(cap_wave.size()), 32'(vecs[v].exp_len));
      model_bits.delete();
      buildFrame(vecs[v].data, vecs[v].mode, vecs[v].two);
      checkWave($sformatf("vec%0d", v), bc);
      if (vecs[v].has_par)
        checkOutput($sformatf("vec%0d_par", v),
                    32'((9 * bc + bc / 2 < cap_wave.size()) ? cap_wave[9 * bc + bc / 2] : 1'bx),
                    32'(vecs[v].exp_par));
      repeat (4) @(negedge clk);
      popRx($sformatf("vec%0d_rx", v), vecs[v].data);
      checkFlags($sformatf("vec%0d", v), 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] back-to-back 0x3C/0xFF, even parity, two stop, divisor 3");
    divisor     = DW'(3);
    parity_mode = 2'b01;
    two_stop    = 1'b1;
    fork
      captureTx();
      begin
        pushTx(8'h3C);
        pushTx(8'hFF);
      end
    join
    checkOutput("b2b_len", 32'(cap_wave.size()), 32'd1536);
    model_bits.delete();
    buildFrame(8'h3C, 2'b01, 1'b1);
    buildFrame(8'hFF, 2'b01, 1'b1);
    checkWave("b2b", 64);
    checkOutput("b2b_par0", 32'(cap_wave[9 * 64 + 32]),  32'd0);
    checkOutput("b2b_par1", 32'(cap_wave[21 * 64 + 32]), 32'd0);
    repeat (4) @(negedge clk);
    popRx("b2b_rx0", 8'h3C);
    popRx("b2b_rx1", 8'hFF);
    checkFlags("b2b", 1'b0, 1'b0, 1'b0);

    $display("[TB] randomised loopback frames");
    for (int r = 0; r < 12; r++) begin
      rd    = 8'($urandom_range(0, 255));
      rmode = 2'($urandom_range(0, 3));
      rtwo  = 1'($urandom_range(0, 1));
      rdiv  = $urandom_range(0, 2);
      bc    = 16 * (rdiv + 1);
      applyStimulus(rd, rmode, rtwo, rdiv);
      captureTx();
      model_bits.delete();
      buildFrame(rd, rmode, rtwo);
      checkOutput($sformatf("rnd%0d_len", r), 32'(cap_wave.size()), 32'(model_bits.size() * bc));
      checkWave($sformatf("rnd%0d", r), bc);
      repeat (4) @(negedge clk);
      popRx($sformatf("rnd%0d_rx", r), rd);
      checkFlags($sformatf("rnd%0d", r), 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] RX parity error, framing error and glitch");
    loopback    = 1'b0;
    drv_rx      = 1'b1;
    divisor     = '0;
    parity_mode = 2'b01;
    driveRxFrame(8'h01, 1'b1, 1'b0, 1'b1);
    checkFlags("perr", 1'b1, 1'b0, 1'b0);
    popRx("perr_rx", 8'h01);
    clearErrors();
    checkFlags("perr_clr", 1'b0, 1'b0, 1'b0);

    parity_mode = 2'b00;
    driveRxFrame(8'h55, 1'b0, 1'b0, 1'b0);
    checkFlags("ferr", 1'b0, 1'b1, 1'b0);
    popRx("ferr_rx", 8'h55);
    @(negedge clk);
    checkOutput("ferr_no_extra", 32'(rx_valid), 32'd0);
    clearErrors();

    @(posedge clk); #1;
    drv_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 drv_rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch_no_byte", 32'(rx_valid), 32'd0);
    checkFlags("glitch", 1'b0, 1'b0, 1'b0);

    $display("[TB] RX overrun with 17 frames");
    for (int i = 0; i < 17; i++) driveRxFrame(8'(i), 1'b0, 1'b0, 1'b1);
    checkFlags("ovr", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) popRx($sformatf("ovr_rx%0d", i), 8'(i));
    @(negedge clk);
    checkOutput("ovr_lost", 32'(rx_valid), 32'd0);

    $display("[TB] reset mid-frame");
    driveRxFrame(8'h66, 1'b0, 1'b0, 1'b0);
    loopback = 1'b1;
    pushTx(8'h5A);
    guard = 0;
    @(negedge clk);
    while (!tx_busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (50) @(negedge clk);
    checkOutput("pre_rst_busy", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mrst_tx",       32'(tx_line),    32'd1);
    checkOutput("mrst_busy",     32'(tx_busy),    32'd0);
    checkOutput("mrst_ready",    32'(tx_ready),   32'd1);
    checkOutput("mrst_rx_valid", 32'(rx_valid),   32'd0);
    checkOutput("mrst_rx_data",  32'(rx_data),    32'd0);
    checkOutput("mrst_perr",     32'(parity_err), 32'd0);
    checkOutput("mrst_ferr",     32'(frame_err),  32'd0);
    checkOutput("mrst_ovr",      32'(overrun),    32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] TX FIFO full at divisor 100");
    loopback = 1'b0;
    drv_rx   = 1'b1;
    divisor  = DW'(100);
    doReset();
    for (int i = 0; i < 16; i++) pushTx(8'(8'h10 + i));
    @(negedge clk);
    checkOutput("full_ready", 32'(tx_ready), 32'd0);
    @(posedge clk); #1;
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    checkOutput("full_ready_hold", 32'(tx_ready), 32'd0);
    guard = 0;
    while (!tx_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("full_ready_after_pop", 32'(tx_ready), 32'd1);
    checkOutput("full_busy_after_pop",  32'(tx_busy),  32'd1);
    pushTx(8'h77);
    @(negedge clk);
    checkOutput("full_refill_ready", 32'(tx_ready), 32'd0);
    doReset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
